// File: rtl/clic_gateway.sv
// rtl/clic_gateway.sv - per-source CLIC interrupt gateway: sync, trigger shaping, edge-pending state
`timescale 1ns/1ps
module clic_gateway #(
  parameter int  N_SOURCE   = 256,
  parameter int  SyncStages = 2,
  localparam int IdxWidth   = $clog2(N_SOURCE)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_SOURCE-1:0]      intr_src_i,
  input  logic [N_SOURCE-1:0][1:0] trig_i,
  input  logic [N_SOURCE-1:0]      claim_i,
  output logic [N_SOURCE-1:0]      ip_o,
  output logic [N_SOURCE-1:0]      le_o,
  input  logic                     sw_we_i,
  input  logic                     sw_re_i,
  input  logic [IdxWidth-1:0]      sw_idx_i,
  input  logic                     sw_wdata_i,
  output logic                     sw_rvalid_o,
  output logic [1:0]               sw_rdata_o,
  output logic [N_SOURCE-1:0]      missed_o
);

  logic [N_SOURCE-1:0] s, pol, p, edge_det;
  logic [N_SOURCE-1:0] prev_q, edge_q, ip_q, ip_d, missed_q, missed_d;
  logic                sw_rvalid_q;
  logic [1:0]          sw_rdata_q, rd_sel;

  if (SyncStages == 0) begin : g_no_sync
    assign s = intr_src_i;
  end else begin : g_sync
    logic [N_SOURCE-1:0] sync_q [SyncStages];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < SyncStages; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= intr_src_i;
        for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s = sync_q[SyncStages-1];
  end

  always_comb begin
    le_o = '0;
    pol  = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      le_o[i] = trig_i[i][0];
      pol[i]  = trig_i[i][1];
    end
  end

  // Polarity is folded in before edge detection so falling-edge sources look like rising ones
  assign p        = s ^ pol;
  assign edge_det = p & ~prev_q;

  always_comb begin
    ip_d     = ip_q;
    missed_d = missed_q;
    for (int i = 0; i < N_SOURCE; i++) begin
      if (!le_o[i]) begin
        ip_d[i] = p[i];
      end else if (!edge_q[i]) begin
        // Entering edge mode discards level-era state; only a fresh edge survives
        ip_d[i]     = edge_det[i];
        missed_d[i] = 1'b0;
      end else begin
        if (edge_det[i]) begin
          ip_d[i] = 1'b1;
        end else if (sw_we_i && (sw_idx_i == IdxWidth'(i))) begin
          ip_d[i] = sw_wdata_i;
        end else if (claim_i[i]) begin
          ip_d[i] = 1'b0;
        end

        if (edge_det[i] && ip_q[i] && !claim_i[i]) begin
          missed_d[i] = 1'b1;
        end else if (sw_we_i && (sw_idx_i == IdxWidth'(i))) begin
          missed_d[i] = 1'b0;
        end
      end
    end
  end

  // Indices beyond N_SOURCE match no entry and therefore read as zero
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      if (sw_idx_i == IdxWidth'(i)) rd_sel = {missed_q[i], ip_q[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q      <= '0;
      edge_q      <= '0;
      ip_q        <= '0;
      missed_q    <= '0;
      sw_rvalid_q <= 1'b0;
      sw_rdata_q  <= '0;
    end else begin
      prev_q      <= p;
      edge_q      <= le_o;
      ip_q        <= ip_d;
      missed_q    <= missed_d;
      sw_rvalid_q <= sw_re_i;
      if (sw_re_i) sw_rdata_q <= rd_sel;
    end
  end

  assign ip_o        = ip_q;
  assign missed_o    = missed_q;
  assign sw_rvalid_o = sw_rvalid_q;
  assign sw_rdata_o  = sw_rdata_q;

endmodule

// File: tb/tb_clic_gateway.sv
// tb/tb_clic_gateway.sv - directed vector bench for clic_gateway
`timescale 1ns/1ps
module tb_clic_gateway;
  localparam int N  = 12;
  localparam int IW = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      intr_src_i;
  logic [N-1:0][1:0] trig_i;
  logic [N-1:0]      claim_i;
  logic [N-1:0]      ip_o;
  logic [N-1:0]      le_o;
  logic              sw_we_i;
  logic              sw_re_i;
  logic [IW-1:0]     sw_idx_i;
  logic              sw_wdata_i;
  logic              sw_rvalid_o;
  logic [1:0]        sw_rdata_o;
  logic [N-1:0]      missed_o;

  always #5 clk_i = ~clk_i;

  clic_gateway #(.N_SOURCE(N), .SyncStages(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .intr_src_i(intr_src_i), .trig_i(trig_i),
    .claim_i(claim_i), .ip_o(ip_o), .le_o(le_o), .sw_we_i(sw_we_i), .sw_re_i(sw_re_i),
    .sw_idx_i(sw_idx_i), .sw_wdata_i(sw_wdata_i), .sw_rvalid_o(sw_rvalid_o),
    .sw_rdata_o(sw_rdata_o), .missed_o(missed_o)
  );

  typedef struct {
    logic [N-1:0]  intr;
    logic [N-1:0]  claim;
    logic          we;
    logic          re;
    logic [IW-1:0] idx;
    logic          wd;
    logic [N-1:0]  ip;
    logic [N-1:0]  missed;
    logic          rv;
    logic [1:0]    rd;
  } vec_t;

  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic [N-1:0] intr, logic [N-1:0] claim, logic we, logic re,
                              logic [IW-1:0] idx, logic wd, logic [N-1:0] ip,
                              logic [N-1:0] missed, logic rv, logic [1:0] rd);
    vec_t v;
    v.intr = intr; v.claim = claim; v.we = we; v.re = re; v.idx = idx; v.wd = wd;
    v.ip = ip; v.missed = missed; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; intr_src_i = '0; claim_i = '0;
    sw_we_i = 1'b0; sw_re_i = 1'b0; sw_idx_i = '0; sw_wdata_i = 1'b0;
    trig_i = '0;
    trig_i[3] = 2'b01; trig_i[7] = 2'b01; trig_i[9] = 2'b01;

    //            intr     claim    we re idx wd ip       missed   rv rd
    tbl.push_back(mk(12'h020, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h020, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h020, 12'h000, 0, 0, 0, 0, 12'h020, 12'h000, 0, 0));
    tbl.push_back(mk(12'h020, 12'h020, 0, 0, 0, 0, 12'h020, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h020, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h020, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h080, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h080, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h080, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h080, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h080, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h080, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h080, 12'h000, 0, 0, 0, 0, 12'h080, 12'h000, 0, 0));
    tbl.push_back(mk(12'h080, 12'h080, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h080, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h008, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h008, 12'h000, 0, 0));
    tbl.push_back(mk(12'h008, 12'h000, 0, 0, 0, 0, 12'h008, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h008, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h008, 12'h008, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 1, 3, 0, 12'h008, 12'h008, 1, 3));
    tbl.push_back(mk(12'h000, 12'h000, 1, 1, 3, 0, 12'h000, 12'h000, 1, 3));
    tbl.push_back(mk(12'h000, 12'h000, 0, 1, 3, 0, 12'h000, 12'h000, 1, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h200, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h200, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h200, 12'h000, 0, 0));
    tbl.push_back(mk(12'h200, 12'h000, 0, 0, 0, 0, 12'h200, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h200, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h200, 0, 0, 0, 0, 12'h200, 12'h000, 0, 0));
    tbl.push_back(mk(12'h200, 12'h000, 0, 0, 0, 0, 12'h200, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 0, 0, 0, 12'h200, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 1, 0, 9, 0, 12'h200, 12'h200, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 1, 0, 9, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 1, 0, 13, 1, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 1, 0, 3, 1, 12'h008, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 0, 1, 3, 0, 12'h008, 12'h000, 1, 1));
    tbl.push_back(mk(12'h000, 12'h000, 0, 1, 14, 0, 12'h008, 12'h000, 1, 0));
    tbl.push_back(mk(12'h000, 12'h008, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(12'h000, 12'h000, 1, 0, 5, 1, 12'h000, 12'h000, 0, 0));

    repeat (2) @(negedge clk_i);
    chk("reset ip", ip_o, 0);
    chk("reset missed", missed_o, 0);
    chk("reset rvalid", sw_rvalid_o, 0);
    chk("reset rdata", sw_rdata_o, 0);
    chk("le mirrors trig", le_o, 12'h288);
    rst_ni = 1'b1;
    cyc(); cyc();
    chk("post-reset ip", ip_o, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      intr_src_i = tbl[k].intr; claim_i = tbl[k].claim;
      sw_we_i = tbl[k].we; sw_re_i = tbl[k].re; sw_idx_i = tbl[k].idx; sw_wdata_i = tbl[k].wd;
      cyc();
      chk($sformatf("row%0d ip", k), ip_o, tbl[k].ip);
      chk($sformatf("row%0d missed", k), missed_o, tbl[k].missed);
      chk($sformatf("row%0d rvalid", k), sw_rvalid_o, tbl[k].rv);
      if (tbl[k].rv) chk($sformatf("row%0d rdata", k), sw_rdata_o, tbl[k].rd);
    end
    intr_src_i = '0; claim_i = '0; sw_we_i = 1'b0; sw_re_i = 1'b0;

    // Source 2: active-low edge, then back to active-low level
    intr_src_i[2] = 1'b1;
    repeat (3) cyc();
    chk("src2 level high", ip_o, 12'h004);
    trig_i[2] = 2'b11;
    cyc();
    chk("src2 switch to falling edge", ip_o, 12'h000);
    chk("src2 le", le_o, 12'h28c);
    intr_src_i[2] = 1'b0;
    cyc(); cyc();
    chk("src2 fall latency", ip_o, 12'h000);
    cyc();
    chk("src2 fall pends", ip_o, 12'h004);
    claim_i[2] = 1'b1;
    cyc();
    claim_i[2] = 1'b0;
    chk("src2 claim", ip_o, 12'h000);
    intr_src_i[2] = 1'b1;
    repeat (4) cyc();
    chk("src2 rise no pend", ip_o, 12'h000);
    chk("src2 rise no missed", missed_o, 12'h000);
    trig_i[2] = 2'b10;
    intr_src_i[2] = 1'b0;
    repeat (3) cyc();
    chk("src2 level low pends", ip_o, 12'h004);
    intr_src_i[2] = 1'b1;
    cyc(); cyc();
    chk("src2 level hold", ip_o, 12'h004);
    cyc();
    chk("src2 level clears", ip_o, 12'h000);

    // Source 4: level to edge while line high and pending
    intr_src_i[4] = 1'b1;
    repeat (3) cyc();
    chk("src4 level pend", ip_o, 12'h010);
    trig_i[4] = 2'b01;
    cyc();
    chk("src4 mode switch clears", ip_o, 12'h000);
    cyc(); cyc();
    chk("src4 high no re-pend", ip_o, 12'h000);

    // Reset in the middle of a pend with a read in flight
    trig_i[4] = 2'b00;
    intr_src_i[4] = 1'b0;
    intr_src_i[7] = 1'b1;
    repeat (3) cyc();
    chk("src7 pend before reset", ip_o, 12'h080);
    sw_re_i = 1'b1; sw_idx_i = 4'd7;
    cyc();
    sw_re_i = 1'b0;
    chk("read before reset rvalid", sw_rvalid_o, 1);
    chk("read before reset rdata", sw_rdata_o, 2'b01);
    rst_ni = 1'b0;
    #1;
    chk("async reset ip", ip_o, 0);
    chk("async reset missed", missed_o, 0);
    chk("async reset rvalid", sw_rvalid_o, 0);
    chk("async reset rdata", sw_rdata_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clic_gateway.md
# clic_gateway

Per-source interrupt gateway placed in front of the CLIC target arbiter. It synchronises raw interrupt lines and applies the per-source trigger attribute (level/edge, polarity). It holds the edge-pending bits, which are set by edges and cleared by the arbiter's claim pulse or by software. It drives the arbiter's `ip`/`le` inputs and gives the register file a set/clear/read port for pending state.

## Interface
- `N_SOURCE`, default 256: number of interrupt sources (≥2).
- `SyncStages`, default 2: synchroniser depth on `intr_src_i`; 0 means bypass (inputs already synchronous).
- `IdxWidth`, localparam, `$clog2(N_SOURCE)`.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous, active-low reset
- `intr_src_i`  in  N_SOURCE  raw interrupt lines
- `trig_i`  in  2 × N_SOURCE  per-source attribute: bit0 = edge (1) / level (0); bit1 = active-low/falling (1)
- `claim_i`  in  N_SOURCE  one-cycle claim pulse from the arbiter
- `ip_o`  out  N_SOURCE  pending vector to the arbiter
- `le_o`  out  N_SOURCE  edge-mode flag to the arbiter; equals `trig_i[i][0]`, combinational
- `sw_we_i`  in  1  software pending write strobe
- `sw_re_i`  in  1  software read strobe
- `sw_idx_i`  in  IdxWidth  source index for read/write
- `sw_wdata_i`  in  1  value to write to the pending bit
- `sw_rvalid_o`  out  1  read data valid, one cycle after `sw_re_i`
- `sw_rdata_o`  out  2  {missed, ip} of the indexed source
- `missed_o`  out  N_SOURCE  sticky flag: an edge arrived while the source was already pending

## Operation
- Synchroniser: `SyncStages` flops per source, reset 0. Its output is `s[i]`.
- Normalised source: `p[i] = s[i] ^ trig_i[i][1]`.
- `prev_q[i]` registers `p[i]` every cycle regardless of mode; reset 0.
- Rising edge: `edge[i] = p[i] & ~prev_q[i]`.
- Level mode (`trig_i[i][0]=0`):
  - `ip_q[i] <= p[i]` every cycle.
  - `claim_i`, `sw_we_i` and missed detection are ignored for that source.
- Edge mode: next-state priority, highest first:
  1. `edge[i]` → `ip_q=1`. An edge wins over a same-cycle claim or software clear, so no hardware event is lost.
  2. Software write with `sw_idx_i==i` → `ip_q=sw_wdata_i`. Software wins over a same-cycle claim.
  3. `claim_i[i]` → `ip_q=0`.
  4. Otherwise hold.
- Missed flag, edge mode only:
  - Set when `edge[i] & ip_q[i] & ~claim_i[i]`.
  - Cleared by any software write to index `i`; set wins if both occur in the same cycle.
  - Held in level mode.
- Mode change: `edge_q[i]` registers `trig_i[i][0]`. On a level→edge transition (`trig_i[i][0] & ~edge_q[i]`), `ip_q[i]` and `missed_q[i]` are cleared in that cycle, unless `edge[i]` is also true, in which case `ip_q=1`. On edge→level, `ip_q` follows `p` from the next cycle.
- Read port: on `sw_re_i`, capture `{missed_q, ip_q}[sw_idx_i]` into `sw_rdata_q` and set `sw_rvalid_q=1` for exactly one cycle.
  - Read data is the pre-update value of that cycle.
  - A read and a write to the same index in the same cycle returns the old value.
- Outputs: `ip_o = ip_q`, `missed_o = missed_q`, `sw_rdata_o = sw_rdata_q`, `sw_rvalid_o = sw_rvalid_q`.
- Out-of-range `sw_idx_i` (≥ N_SOURCE): writes are dropped; reads return 0 with valid asserted.

## Timing
- Reset values: `ip_o=0`, `missed_o=0`, `sw_rvalid_o=0`, `sw_rdata_o=0`. Synchroniser, `prev_q` and `edge_q` reset to 0.
  - Consequence: an active-low source is held at 1 in reset, gives p=1 after reset, and produces one edge, i.e. one pending event, after reset. This is intended.
- `le_o` is combinational from `trig_i`.
- Source edge → `ip_o`: `SyncStages+1` cycles in both modes (2 cycles from the synchroniser output to `ip_o` is not allowed; it is 1).
- `claim_i[i]` at cycle t → `ip_o[i]=0` at t+1, absent a new edge at t.
- Software write at cycle t takes effect at t+1.
- Read: `sw_re_i` at t → `sw_rvalid_o`/`sw_rdata_o` at t+1. Back-to-back reads are supported at one per cycle.
- A continuously high source in edge mode pends once. After a claim it does not re-pend until a low→high transition.
- Reset asserted mid-operation clears all state asynchronously. No pending events are retained.

## Test plan
- Level mode, `SyncStages=2`, source 5 driven 0→1 at t0 → `ip_o[5]=1` at t0+3; 1→0 → clears at +3; `claim_i[5]` has no effect.
- Edge mode, source 7: pulse 1 cycle → `ip_o[7]` set and held; `claim_i[7]` → 0 the next cycle; line held high → no re-pend.
- Edge mode, source 3: second edge while pending and unclaimed → `missed_o[3]=1`. Software write idx 3 with data 0 → `ip_o[3]=0`, `missed_o[3]=0`. Read idx 3 → `sw_rdata_o=2'b00`, valid for 1 cycle.
- Simultaneous events, source 9, edge mode: edge and claim in the same cycle → `ip_o[9]` stays 1, missed stays 0. Software clear and edge in the same cycle → `ip_o[9]=1`.
- Polarity: `trig_i[2]=2'b11`, line 1→0 → `ip_o[2]` pends; 0→1 → no new pend. Switching to level mode → `ip_o[2]` mirrors `~line`.
- Level→edge switch with line high and `ip_q=1` → `ip_o` cleared next cycle; reset pulse mid-pend → all outputs 0 immediately.
